register16_bank_arb: RTL and testbench

Shared bank of NREG 16-bit registers written by NREQ independent requesters through a round-robin arbiter, with one registered read port. It sits between the datapath clients and the 16-bit storage registers and sequences all writes so that at most one write lands per clock. It also counts completed writes for debug.

---
 rtl/register16_bank_arb.sv | 144 ++++++++++++++
 tb/tb_register16_bank_arb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/register16_bank_arb.sv
// register16_bank_arb: NREG x 16-bit register bank shared by NREQ writers
// through a round-robin arbiter, one registered read port and a wrapping
// write counter.
//
// Build option: define REGBANK_LOCK_EN to let the current owner hold the
// grant via its lock bit for up to 16 consecutive grants. Without it the
// lock port is ignored and arbitration is pure round-robin.
//
// state | meaning
// IDLE  | no owner, grant = 0
// GRANT | one requester owns the bank; its write commits at the cycle's end
module register16_bank_arb #(
    parameter  int NREQ = 4,
    parameter  int NREG = 4,
    localparam int AW   = $clog2(NREG),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] waddr,
    input  logic [NREQ*16-1:0] wdata,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    input  logic [AW-1:0]      rd_addr,
    output logic [15:0]        rd_data,
    output logic [7:0]         wr_count
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]        state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gidx;
    logic [15:0]       regs [NREG];

    logic [IW-1:0]     adv_ptr;
    logic [IW-1:0]     base;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [IW:0]       win_sum;
    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [NREQ-1:0]   win_onehot;
    logic [AW-1:0]     sel_addr;
    logic [15:0]       sel_data;
    logic              lock_keep;

    assign busy = (state == ST_GRANT);

    // Round-robin search: rotate req so the base pointer lands at bit 0,
    // take the lowest set bit, then map it back to a requester index.
    always_comb begin
        adv_ptr    = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        base       = (state == ST_GRANT) ? adv_ptr : ptr;
        req_dbl    = {req, req} >> base;
        req_rot    = req_dbl[NREQ-1:0];
        win_found  = |req_rot;
        win_sum    = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_rot[j]) win_sum = {1'b0, base} + (IW+1)'(j);
        end
        win_idx    = (win_sum >= (IW+1)'(NREQ)) ? IW'(win_sum - (IW+1)'(NREQ))
                                                : win_sum[IW-1:0];
        win_onehot = '0;
        win_onehot[win_idx] = 1'b1;
    end

    // Select the owning requester's address and data lanes.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IW'(i)) begin
                sel_addr = waddr[i*AW +: AW];
                sel_data = wdata[i*16 +: 16];
            end
        end
    end

`ifdef REGBANK_LOCK_EN
    logic [3:0] lock_cnt;

    // Owner keeps the bank while it asks for it, capped at 16 grants in a row.
    assign lock_keep = (state == ST_GRANT) && lock[gidx] && req[gidx]
                       && (lock_cnt != 4'd15);

    // Counts extra grants taken by the current owner; cleared on hand-over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt <= '0;
        end else if (state == ST_GRANT) begin
            lock_cnt <= lock_keep ? lock_cnt + 4'd1 : 4'd0;
        end
    end
`else
    logic unused_lock;

    assign lock_keep   = 1'b0;
    assign unused_lock = ^lock;
`endif

    // Arbiter FSM, write commit, read port and write counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            gidx     <= '0;
            ptr      <= '0;
            rd_data  <= '0;
            wr_count <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            rd_data <= regs[rd_addr];
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state <= ST_GRANT;
                        grant <= win_onehot;
                        gidx  <= win_idx;
                    end
                end
                default: begin
                    // The grant cycle is the commit, whether or not req is still up.
                    regs[sel_addr] <= sel_data;
                    wr_count       <= wr_count + 8'd1;
                    if (!lock_keep) begin
                        ptr <= adv_ptr;
                        if (win_found) begin
                            grant <= win_onehot;
                            gidx  <= win_idx;
                        end else begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register16_bank_arb.sv
// Directed bench for register16_bank_arb (4 requesters, 4 registers).
// Define REGBANK_LOCK_EN here as for the RTL to check the lock build.
module tb_register16_bank_arb;

    localparam int NREQ = 4;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] waddr;
    logic [NREQ*16-1:0] wdata;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [AW-1:0]      rd_addr;
    logic [15:0]        rd_data;
    logic [7:0]         wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    register16_bank_arb #(.NREQ(NREQ), .NREG(NREG)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .waddr    (waddr),
        .wdata    (wdata),
        .grant    (grant),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [15:0] d);
        waddr[i*AW +: AW] = a;
        wdata[i*16 +: 16] = d;
    endtask

    initial begin
        logic [3:0] exp_g;

        // Reset with every requester asking.
        reset   = 1'b0;
        req     = 4'b1111;
        lock    = '0;
        waddr   = '0;
        wdata   = '0;
        rd_addr = '0;
        tick(); tick(); tick();
        check("rst_grant", grant, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_data", rd_data, 16'h0000);
        check("rst_wr_count", wr_count, 8'd0);
        req   = '0;
        reset = 1'b1;
        tick();

        // Single write from requester 2.
        set_lane(2, 2'd1, 16'h000F);
        req = 4'b0100;
        tick();
        check("single_grant", grant, 4'b0100);
        check("single_busy", busy, 1'b1);
        req     = '0;
        rd_addr = 2'd1;
        tick();
        check("single_idle", grant, 4'b0000);
        check("single_count", wr_count, 8'd1);
        check("single_rd_early", rd_data, 16'h0000);
        tick();
        check("single_rd", rd_data, 16'h000F);

        // Contention: all four held for 8 cycles right after reset.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_lane(i, AW'(i), 16'h1000 + 16'(i));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_g = 4'b0001 << (k % 4);
            check($sformatf("rr_grant_%0d", k), grant, exp_g);
            check($sformatf("rr_busy_%0d", k), busy, 1'b1);
        end
        req = '0;
        tick();
        check("rr_count", wr_count, 8'd8);
        check("rr_idle", grant, 4'b0000);
        rd_addr = 2'd2;
        tick();
        check("rr_readback", rd_data, 16'h1002);

        // Read/write collision on reg[3].
        set_lane(0, 2'd3, 16'h1234);
        req = 4'b0001;
        tick();
        check("coll_grant_a", grant, 4'b0001);
        req = '0;
        tick();
        rd_addr = 2'd3;
        set_lane(0, 2'd3, 16'h5678);
        req = 4'b0001;
        tick();
        check("coll_grant_b", grant, 4'b0001);
        check("coll_pre", rd_data, 16'h1234);
        req = '0;
        tick();
        check("coll_old", rd_data, 16'h1234);
        tick();
        check("coll_new", rd_data, 16'h5678);

        // Reset in the middle of a grant to reg[0]; ptr sits at 1 beforehand.
        set_lane(0, 2'd0, 16'hABCD);
        req = 4'b0001;
        tick();
        check("mid_grant", grant, 4'b0001);
        reset = 1'b0;
        #1;
        check("mid_grant_clr", grant, 4'b0000);
        check("mid_busy_clr", busy, 1'b0);
        req = '0;
        tick();
        reset   = 1'b1;
        rd_addr = 2'd0;
        tick();
        check("mid_reg0", rd_data, 16'h0000);
        check("mid_count", wr_count, 8'd0);
        rd_addr = 2'd3;
        req     = 4'b1111;
        tick();
        check("mid_reg3", rd_data, 16'h0000);
        check("mid_ptr0", grant, 4'b0001);
        req = '0;
        tick();

        // Lock: requester 0 asks to hold, requester 1 competes.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        lock  = 4'b0001;
        req   = 4'b0011;
        for (int k = 0; k < 18; k++) begin
            tick();
`ifdef REGBANK_LOCK_EN
            exp_g = (k == 16) ? 4'b0010 : 4'b0001;
`else
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            check($sformatf("lock_grant_%0d", k), grant, exp_g);
        end
        req  = '0;
        lock = '0;
        tick();
        check("lock_count", wr_count, 8'd18);
        check("lock_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
